// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU: instruction fields, shift codes,
// controller states and ALU operations.
package cpu_pkg;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WRITE_REG,
        S_WRITE_IMM
    } state_t;

    // Values line up with the op field of ALU-class instructions.
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_NOT = 2'b11
    } alu_op_t;

    function automatic logic [15:0] shift16(input logic [15:0] x, input logic [1:0] sh);
        logic [15:0] r;
        case (sh)
            SH_LSL:  r = {x[14:0], 1'b0};
            SH_LSR:  r = {1'b0, x[15:1]};
            SH_ASR:  r = {x[15], x[15:1]};
            default: r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_datapath.sv
// Register file, A/B/C operand registers, Rm shifter, ALU and NVZ status.
// All state updates are gated by the strobes from the controller in cpu_core.
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  rn,
    input  logic [2:0]  rd,
    input  logic [2:0]  rm,
    input  logic [1:0]  sh,
    input  logic [15:0] sximm8,
    input  logic        load_a,
    input  logic        load_b,
    input  logic        load_c,
    input  logic        load_s,
    input  logic        asel,
    input  alu_op_t     alu_op,
    input  logic        write_reg,
    input  logic        write_imm,
    output logic [15:0] c,
    output logic        n,
    output logic        v,
    output logic        z
);

    logic [15:0] regs [8];
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ain;
    logic [15:0] bin;
    logic [15:0] diff;
    logic [15:0] result;
    logic        ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (write_imm) begin
            regs[rn] <= sximm8;
        end else if (write_reg) begin
            regs[rd] <= c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a <= '0;
            b <= '0;
        end else begin
            if (load_a) a <= regs[rn];
            if (load_b) b <= regs[rm];
        end
    end

    // asel substitutes zero for A so MOV reg can reuse the adder path.
    always_comb begin
        bin    = shift16(b, sh);
        ain    = asel ? '0 : a;
        diff   = ain - bin;
        result = ain + bin;
        case (alu_op)
            ALU_ADD: result = ain + bin;
            ALU_SUB: result = diff;
            ALU_AND: result = ain & bin;
            ALU_NOT: result = ~bin;
        endcase
        ovf = (ain[15] ^ bin[15]) & (diff[15] ^ ain[15]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c <= '0;
            n <= 1'b0;
            v <= 1'b0;
            z <= 1'b0;
        end else begin
            if (load_c) c <= result;
            if (load_s) begin
                n <= diff[15];
                v <= ovf;
                z <= (diff == 16'h0000);
            end
        end
    end

endmodule

// File: rtl/cpu_core.sv
// Multicycle 16-bit CPU top: instruction register, decoder and controller FSM
// driving cpu_datapath; w is high only while the controller idles in WAIT.
module cpu_core
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic [15:0] out,
    output logic        N,
    output logic        V,
    output logic        Z,
    output logic        w
);

    logic [15:0] ir;
    state_t      state;
    state_t      next_state;

    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [15:0] sximm8;
    logic        is_mov_imm;
    logic        is_mov_reg;
    logic        is_alu;
    logic        is_cmp;

    logic        load_a;
    logic        load_b;
    logic        load_c;
    logic        load_s;
    logic        write_reg;
    logic        write_imm;
    logic        asel;
    alu_op_t     alu_op;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ir <= '0;
        else if (load) ir <= in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_WAIT;
        else state <= next_state;
    end

    assign opcode     = ir[15:13];
    assign op         = ir[12:11];
    assign sximm8     = {{8{ir[7]}}, ir[7:0]};
    assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    assign is_alu     = (opcode == OPC_ALU);
    assign is_cmp     = is_alu && (op == OP_CMP);

    always_comb begin
        next_state = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_c     = 1'b0;
        load_s     = 1'b0;
        write_reg  = 1'b0;
        write_imm  = 1'b0;
        asel       = is_mov_reg;
        alu_op     = is_alu ? alu_op_t'(op) : ALU_ADD;
        case (state)
            S_WAIT: if (s) next_state = S_DECODE;
            S_DECODE: begin
                if (is_mov_imm)                            next_state = S_WRITE_IMM;
                else if (is_mov_reg || (is_alu && op == OP_MVN)) next_state = S_GET_B;
                else if (is_alu)                           next_state = S_GET_A;
                else                                       next_state = S_WAIT;
            end
            S_GET_A: begin
                load_a     = 1'b1;
                next_state = S_GET_B;
            end
            S_GET_B: begin
                load_b     = 1'b1;
                next_state = S_ALU;
            end
            S_ALU: begin
                load_c     = !is_cmp;
                load_s     = is_cmp;
                next_state = is_cmp ? S_WAIT : S_WRITE_REG;
            end
            S_WRITE_REG: begin
                write_reg  = 1'b1;
                next_state = S_WAIT;
            end
            S_WRITE_IMM: begin
                write_imm  = 1'b1;
                next_state = S_WAIT;
            end
            default: next_state = S_WAIT;
        endcase
    end

    assign w = (state == S_WAIT);

    cpu_datapath u_datapath (
        .clk       (clk),
        .reset     (reset),
        .rn        (ir[10:8]),
        .rd        (ir[7:5]),
        .rm        (ir[2:0]),
        .sh        (ir[4:3]),
        .sximm8    (sximm8),
        .load_a    (load_a),
        .load_b    (load_b),
        .load_c    (load_c),
        .load_s    (load_s),
        .asel      (asel),
        .alu_op    (alu_op),
        .write_reg (write_reg),
        .write_imm (write_imm),
        .c         (out),
        .n         (N),
        .v         (V),
        .z         (Z)
    );

endmodule

// File: tb/tb_cpu_core.sv
// Directed-vector bench for cpu_core: instruction table with expected C, NVZ
// and latency, plus hand sequences for load gating, idle and mid-instruction reset.
module tb_cpu_core;

    logic        clk;
    logic        reset;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic [15:0] out;
    logic        N;
    logic        V;
    logic        Z;
    logic        w;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] exp_out;
        logic [2:0]  exp_nvz;
        int          exp_lat;
    } vec_t;

    vec_t tbl [22];

    cpu_core dut (
        .clk   (clk),
        .reset (reset),
        .s     (s),
        .load  (load),
        .in    (in),
        .out   (out),
        .N     (N),
        .V     (V),
        .Z     (Z),
        .w     (w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Starts one instruction from WAIT and counts cycles spent outside WAIT.
    task automatic run_instr(input logic [15:0] instr, input logic do_load,
                             output int lat, output logic saw8);
        @(negedge clk);
        in   = instr;
        load = do_load;
        @(negedge clk);
        load = 1'b0;
        s    = 1'b1;
        @(negedge clk);
        s    = 1'b0;
        lat  = 0;
        saw8 = 1'b0;
        while (w == 1'b0 && lat < 50) begin
            lat++;
            if (out == 16'h0008) saw8 = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic apply_vec(input int i);
        int   lat;
        logic saw8;
        run_instr(tbl[i].instr, 1'b1, lat, saw8);
        check($sformatf("v%0d_%04h out", i, tbl[i].instr), {16'h0, out}, {16'h0, tbl[i].exp_out});
        check($sformatf("v%0d_%04h nvz", i, tbl[i].instr), {29'h0, N, V, Z}, {29'h0, tbl[i].exp_nvz});
        check($sformatf("v%0d_%04h latency", i, tbl[i].instr), lat, tbl[i].exp_lat);
    endtask

    initial begin
        int   lat;
        logic saw8;

        tbl[0]  = '{16'hD004, 16'h0000, 3'b000, 2};  // MOV R0,#4
        tbl[1]  = '{16'hC020, 16'h0004, 3'b000, 4};  // MOV R1,R0
        tbl[2]  = '{16'hD273, 16'h0004, 3'b000, 2};  // MOV R2,#115
        tbl[3]  = '{16'hA269, 16'h007B, 3'b000, 5};  // ADD R3,R2,R1,LSL#1
        tbl[4]  = '{16'hB390, 16'h0002, 3'b000, 5};  // AND R4,R3,R0,LSR#1
        tbl[5]  = '{16'hB8A2, 16'hFF8C, 3'b000, 4};  // MVN R5,R2
        tbl[6]  = '{16'hA811, 16'hFF8C, 3'b000, 4};  // CMP 4-2
        tbl[7]  = '{16'hA809, 16'hFF8C, 3'b100, 4};  // CMP 4-8
        tbl[8]  = '{16'hA801, 16'hFF8C, 3'b001, 4};  // CMP 4-4
        tbl[9]  = '{16'hE000, 16'hFF8C, 3'b001, 1};  // undefined opcode: NOP
        tbl[10] = '{16'hD07F, 16'hFF8C, 3'b001, 2};  // MOV R0,#127
        tbl[11] = '{16'hD680, 16'hFF8C, 3'b001, 2};  // MOV R6,#-128
        tbl[12] = '{16'hC0FE, 16'hFFC0, 3'b001, 4};  // MOV R7,R6,ASR#1
        tbl[13] = '{16'hC0CE, 16'hFF00, 3'b001, 4};  // MOV R6,R6,LSL#1 x8
        tbl[14] = '{16'hC0CE, 16'hFE00, 3'b001, 4};
        tbl[15] = '{16'hC0CE, 16'hFC00, 3'b001, 4};
        tbl[16] = '{16'hC0CE, 16'hF800, 3'b001, 4};
        tbl[17] = '{16'hC0CE, 16'hF000, 3'b001, 4};
        tbl[18] = '{16'hC0CE, 16'hE000, 3'b001, 4};
        tbl[19] = '{16'hC0CE, 16'hC000, 3'b001, 4};
        tbl[20] = '{16'hC0CE, 16'h8000, 3'b001, 4};
        tbl[21] = '{16'hA806, 16'h8000, 3'b110, 4};  // CMP 0x007F-0x8000 overflows

        reset = 1'b0;
        s     = 1'b0;
        load  = 1'b0;
        in    = 16'h0000;
        #1;
        check("reset w", {31'h0, w}, 32'h1);
        check("reset out", {16'h0, out}, 32'h0);
        check("reset nvz", {29'h0, N, V, Z}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 2; i++) apply_vec(i);

        // load held low: IR keeps MOV R1,R0, so the LSL#1 variant never executes
        run_instr(16'hC048, 1'b0, lat, saw8);
        check("noload out", {16'h0, out}, 32'h0004);
        check("noload saw8", {31'h0, saw8}, 32'h0);
        check("noload latency", lat, 4);

        for (int i = 2; i < 22; i++) apply_vec(i);

        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("idle w %0d", k), {31'h0, w}, 32'h1);
        end

        // reset while an ADD sits in GET_B
        @(negedge clk);
        in   = 16'hA269;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        s    = 1'b1;
        @(negedge clk);
        s    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midadd busy w", {31'h0, w}, 32'h0);
        reset = 1'b0;
        #1;
        check("midadd reset w", {31'h0, w}, 32'h1);
        check("midadd reset out", {16'h0, out}, 32'h0);
        check("midadd reset nvz", {29'h0, N, V, Z}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int r = 0; r < 8; r++) begin
            logic [15:0] mov_r0_rr;
            mov_r0_rr = 16'hC000 | 16'(r);
            run_instr(mov_r0_rr, 1'b1, lat, saw8);
            check($sformatf("post-reset R%0d", r), {16'h0, out}, 32'h0);
            check($sformatf("post-reset R%0d latency", r), lat, 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
Name: cpu_core

Overview:
- Multicycle 16-bit CPU: 8×16-bit register file, barrel-style 1-bit shifter, ALU and status flags, under FSM control.
- Instructions arrive on `in`, latched into an instruction register (IR) by `load`, and executed when `s` is asserted.
- `out` exposes the ALU result register C; `w` signals that the controller is idle and waiting.

Parameters:
- None. Data width is fixed at 16 and the register count at 8.

Ports:
- clk  input  1  single system clock; rising-edge active
- reset  input  1  asynchronous, active-low reset
- s  input  1  start; sampled in WAIT
- load  input  1  IR load enable; when 1, IR <= in on the rising edge
- in  input  16  instruction word
- out  output  16  C register (last ALU result)
- N  output  1  negative flag
- V  output  1  signed overflow flag
- Z  output  1  zero flag
- w  output  1  1 only while FSM is in WAIT

Behaviour:
- Reset (reset==0, async): FSM=WAIT; IR, C, R0..R7, N, V, Z all cleared to 0. While in reset, w=1 and out=0.
- IR loads whenever load==1, in any FSM state. An IR change mid-instruction affects the following decode only if the change is visible at DECODE. A bench changes `in` only while the FSM is in WAIT.
- Instruction fields:
  - [15:13] opcode; [12:11] op; [10:8] Rn; [7:5] Rd; [4:3] sh; [2:0] Rm.
  - sximm8 = sign-extended [7:0].
- Shift of the Rm operand, by sh:
  - 00: no shift
  - 01: LSL 1
  - 10: LSR 1 (MSB<=0)
  - 11: ASR 1 (MSB kept)
- Instructions:
  - 110/10 MOV Rn,#imm8: Rn <= sximm8. C and flags unchanged.
  - 110/00 MOV Rd,Rm{,sh}: C <= 0 + sh(Rm); Rd <= C.
  - 101/00 ADD: C <= Rn + sh(Rm); Rd <= C.
  - 101/01 CMP: compute Rn - sh(Rm); update flags; C, Rd unchanged.
  - 101/10 AND: C <= Rn & sh(Rm); Rd <= C.
  - 101/11 MVN: C <= ~sh(Rm); Rd <= C.
  - Any other opcode/op: treated as NOP; DECODE->WAIT, no state changes.
- Flags are updated only by CMP, in the ALU state:
  - Z = (result==0)
  - N = result[15]
  - V = signed overflow of the subtraction
  - Arithmetic is modulo 2^16.
- FSM states: WAIT, DECODE, GET_A, GET_B, ALU, WRITE_REG, WRITE_IMM. One transition per clock.
  - WAIT: s==1 -> DECODE; otherwise stay.
  - DECODE:
    - MOV imm -> WRITE_IMM
    - MOV reg, MVN -> GET_B
    - ADD, AND, CMP -> GET_A
  - GET_A (A <= Rn) -> GET_B.
  - GET_B (B <= Rm) -> ALU.
  - ALU: latch C, plus flags on CMP. CMP -> WAIT; otherwise -> WRITE_REG.
  - WRITE_REG (Rd <= C) -> WAIT.
  - WRITE_IMM (Rn <= sximm8) -> WAIT.
- Latency from leaving WAIT back to WAIT:
  - MOV imm: 2 cycles
  - MOV reg, MVN: 4 cycles
  - CMP: 4 cycles
  - ADD, AND: 5 cycles
- `out` changes only on the ALU-state clock edge.
- If s is held at 1, instructions execute back-to-back, re-reading IR at each DECODE.
- Register reads use values written by earlier instructions. A write in WRITE_REG/WRITE_IMM is visible to the next instruction's GET_A/GET_B.

Decomposition:
- Package cpu_pkg holds:
  - opcode/op constants
  - shift-code constants
  - FSM state enum
  - ALU-op encoding
- Sub-module cpu_datapath holds:
  - register file
  - A/B/C registers
  - shifter, ALU, status register
- cpu_core contains IR, decoder and FSM, and instantiates cpu_datapath.

Test Plan:
- Reset low, then high. Load 0xD004 (MOV R0,#4) and run. Then load 0xC020 (MOV R1,R0) -> out=0x0004, R1=4.
- With load=0, present 0xC048 and pulse s -> IR keeps 0xC020, and out never becomes 0x0008. Then load 0xD273 (R2=115) and run 0xA269 (ADD R3,R2,R1,LSL#1) -> out=123.
- Run 0xB390 (AND R4,R3,R0,LSR#1) -> out=0x0002. Run 0xB8A2 (MVN R5,R2) -> out=0xFF8C.
- Run CMP cases with R0=4, R1=4:
  - 0xA811 -> N=0, Z=0
  - 0xA809 -> N=1
  - 0xA801 -> Z=1, N=0
  - In all cases out is unchanged.
- Overflow: R0=0x7F (MOV #127), build 0x8000 via shifts, then CMP -> V=1. Verify ASR of 0xFF80 gives 0xFFC0.
- s=0 for several cycles -> w=1 and state stays WAIT. Assert reset mid-ADD (GET_B) -> immediately w=1, out=0, and all registers read 0 afterwards.
